// File: rtl/display_timing.sv
// -----------------------------------------------------------------------------
// display_timing
//
// Pixel-clock display timing generator. It produces the current screen
// coordinate (sx, sy) together with horizontal/vertical sync, data enable and
// line/frame start strobes. All timing comes from parameters. The defaults
// give 640x480 at 60 Hz, with 800x525 total pixels and a 25.2 MHz pixel clock.
//
// Ports
//   clk_pix    in   1      pixel clock
//   rst_pix_n  in   1      asynchronous active-low reset (release is already
//                          synchronised to clk_pix upstream)
//   sx         out  CORDW  horizontal position, 0..H_TOT-1
//   sy         out  CORDW  vertical position,   0..V_TOT-1
//   hsync      out  1      horizontal sync, H_POL level during the pulse
//   vsync      out  1      vertical sync,   V_POL level during the pulse
//   de         out  1      data enable, high inside the active area
//   line       out  1      one-cycle strobe at sx==0
//   frame      out  1      one-cycle strobe at sx==0 && sy==0
//
// Every output is a register. The sync, de and strobe decode is taken from
// the *next* counter values. As a result, all outputs in a given cycle
// describe the same (sx, sy) pixel, and the coordinates have zero skew
// against the syncs.
// -----------------------------------------------------------------------------
module display_timing #(
  parameter int CORDW  = 10,
  parameter int H_RES  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_RES  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter bit H_POL  = 1'b0,
  parameter bit V_POL  = 1'b0
) (
  input  logic             clk_pix,
  input  logic             rst_pix_n,
  output logic [CORDW-1:0] sx,
  output logic [CORDW-1:0] sy,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             line,
  output logic             frame
);

  localparam int H_TOT = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_RES + V_FP + V_SYNC + V_BP;

  // The counters must hold their terminal values. If they cannot, refuse to
  // elaborate rather than silently wrapping early.
  generate
    if ((2 ** CORDW) <= H_TOT || (2 ** CORDW) <= V_TOT) begin : g_cordw_too_small
      $error("display_timing: CORDW too narrow for H_TOT/V_TOT");
    end
  endgenerate

  // All decode boundaries are pre-cast to the coordinate width, so every
  // comparison below is an unsigned CORDW-bit compare.
  localparam logic [CORDW-1:0] ONE      = CORDW'(1);
  localparam logic [CORDW-1:0] H_LAST   = CORDW'(H_TOT - 1);
  localparam logic [CORDW-1:0] V_LAST   = CORDW'(V_TOT - 1);
  localparam logic [CORDW-1:0] H_ACT    = CORDW'(H_RES);
  localparam logic [CORDW-1:0] V_ACT    = CORDW'(V_RES);
  localparam logic [CORDW-1:0] HS_START = CORDW'(H_RES + H_FP);
  localparam logic [CORDW-1:0] HS_END   = CORDW'(H_RES + H_FP + H_SYNC);
  localparam logic [CORDW-1:0] VS_START = CORDW'(V_RES + V_FP);
  localparam logic [CORDW-1:0] VS_END   = CORDW'(V_RES + V_FP + V_SYNC);

  // State registers and their next-state values.
  logic [CORDW-1:0] sx_q, sx_d;
  logic [CORDW-1:0] sy_q, sy_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             de_q, de_d;
  logic             line_q, line_d;
  logic             frame_q, frame_d;

  // Wrap flags for the current position.
  logic h_wrap;
  logic v_wrap;

  // Counter next state. sy only advances in the cycle where sx wraps, so the
  // simultaneous wrap at (H_TOT-1, V_TOT-1) lands on (0,0) in one step.
  always_comb begin
    h_wrap = (sx_q == H_LAST);
    v_wrap = (sy_q == V_LAST);
    sx_d   = sx_q;
    sy_d   = sy_q;
    if (h_wrap) begin
      sx_d = '0;
      if (v_wrap) begin
        sy_d = '0;
      end else begin
        sy_d = sy_q + ONE;
      end
    end else begin
      sx_d = sx_q + ONE;
    end
  end

  // Output decode from the next position. Registering these results lines
  // them up with the registered coordinates.
  always_comb begin
    de_d    = (sx_d < H_ACT) && (sy_d < V_ACT);
    hsync_d = ((sx_d >= HS_START) && (sx_d < HS_END)) ? H_POL : ~H_POL;
    vsync_d = ((sy_d >= VS_START) && (sy_d < VS_END)) ? V_POL : ~V_POL;
    line_d  = (sx_d == '0);
    frame_d = (sx_d == '0) && (sy_d == '0);
  end

  // The reset state is the decode of (H_TOT-1, V_TOT-1). The first edge after
  // release therefore presents pixel (0,0) with line and frame asserted.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      sx_q    <= H_LAST;
      sy_q    <= V_LAST;
      hsync_q <= ~H_POL;
      vsync_q <= ~V_POL;
      de_q    <= 1'b0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      line_q  <= line_d;
      frame_q <= frame_d;
    end
  end

  assign sx    = sx_q;
  assign sy    = sy_q;
  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign de    = de_q;
  assign line  = line_q;
  assign frame = frame_q;

endmodule
